// File: rtl/compare_reporter_pkg.sv
// Shared types and record constants for compare_reporter and its serializer.
package compare_reporter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_REC,
    ST_SEND_SUM,
    ST_FINISHED
  } state_e;

  localparam logic [7:0] SYNC_BYTE_C    = 8'hA5;
  localparam logic [7:0] SUM_BYTE_C     = 8'h5A;
  localparam logic [7:0] STAT_PASS_C    = 8'h50;
  localparam logic [7:0] STAT_FAIL_C    = 8'h46;
  localparam logic [7:0] STAT_TIMEOUT_C = 8'h54;

  localparam int REC_LEN_C = 11;
  localparam int SUM_LEN_C = 6;
  localparam int IDX_W_C   = 4;
  localparam int COUNT_W_C = 16;

endpackage

// File: rtl/compare_reporter_ser.sv
// Record serializer: walks a byte index over the supplied record with a
// valid/ready holding register and pulses last_accepted_o on the final byte.
module compare_reporter_ser
  import compare_reporter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [IDX_W_C-1:0]           len_i,
  input  logic [REC_LEN_C-1:0][7:0]    rec_i,
  input  logic                         byte_ready_i,
  output logic                         byte_valid_o,
  output logic [7:0]                   byte_data_o,
  output logic                         last_accepted_o
);

  logic               valid_q, valid_d;
  logic [IDX_W_C-1:0] idx_q, idx_d;
  logic               xfer;

  assign xfer            = valid_q && byte_ready_i;
  assign last_accepted_o = xfer && (idx_q == (len_i - IDX_W_C'(1)));
  // rec_i is driven from registers that stay frozen while a record is out,
  // so the muxed byte is stable for as long as valid is held.
  assign byte_valid_o    = valid_q;
  assign byte_data_o     = valid_q ? rec_i[idx_q] : 8'h00;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (abort_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (start_i) begin
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (last_accepted_o) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (xfer) begin
      idx_d = idx_q + IDX_W_C'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/compare_reporter.sv
// Compares expected/measured pairs, counts results and streams per-test and
// summary records. Optional watchdog: define COMPARE_REPORTER_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; a source holds valid and data unchanged until that edge.
module compare_reporter
  import compare_reporter_pkg::*;
#(
  parameter int         NUMBER_OF_TESTS = 16,
  parameter int         COUNT_W         = COUNT_W_C,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_C,
  parameter logic [7:0] SUM_BYTE        = SUM_BYTE_C
`ifdef COMPARE_REPORTER_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES  = 1_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmp_valid,
  output logic               cmp_ready,
  input  logic [31:0]        cmp_expected,
  input  logic [31:0]        cmp_measured,
  input  logic               done_req,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [7:0]         byte_data,
  output logic [COUNT_W-1:0] test_count,
  output logic [COUNT_W-1:0] fail_count,
  output logic               test_passed,
  output logic               test_failed,
  output state_e             dbg_state
);

  localparam logic [15:0] NUM_TESTS_C = 16'(NUMBER_OF_TESTS);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] test_count_q, test_count_d, fail_count_q, fail_count_d;
  logic               passed_q, passed_d, failed_q, failed_d;
  logic               done_pend_q, done_pend_d, mis_q, mis_d;
  logic [31:0]        expected_q, expected_d, measured_q, measured_d;
  logic [7:0]         idx_q, idx_d;

  logic                      accept, ser_start, ser_last, timeout, timed_out;
  logic [REC_LEN_C-1:0][7:0] rec;
  logic [IDX_W_C-1:0]        rec_len;
  logic [7:0]                result;
  logic [15:0]               tc16;

`ifdef COMPARE_REPORTER_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        to_q;

  // Watchdog freezes once it has fired so the 'T' summary is sent only once.
  assign timeout   = !to_q && (state_q != ST_FINISHED) && (wd_q >= 32'(TIMEOUT_CYCLES));
  assign timed_out = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (timeout) to_q <= 1'b1;
      if (accept || (byte_valid && byte_ready) || timeout) wd_q <= '0;
      else if (!to_q && (state_q != ST_FINISHED)) wd_q <= wd_q + 32'd1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign cmp_ready = (state_q == ST_IDLE) && !timeout;
  assign accept    = cmp_valid && cmp_ready;
  assign tc16      = 16'(test_count_q);

  // A saturated test counter can never be a pass.
  always_comb begin
    if (timed_out)
      result = STAT_TIMEOUT_C;
    else if ((fail_count_q == '0) && (test_count_q == COUNT_W'(NUMBER_OF_TESTS)) &&
             (test_count_q != '1))
      result = STAT_PASS_C;
    else
      result = STAT_FAIL_C;
  end

  always_comb begin
    rec = '0;
    if (state_q == ST_SEND_SUM) begin
      rec_len = IDX_W_C'(SUM_LEN_C);
      rec[0]  = SUM_BYTE;
      rec[1]  = result;
      rec[2]  = tc16[15:8];
      rec[3]  = tc16[7:0];
      rec[4]  = NUM_TESTS_C[15:8];
      rec[5]  = NUM_TESTS_C[7:0];
    end else begin
      rec_len = IDX_W_C'(REC_LEN_C);
      rec[0]  = SYNC_BYTE;
      rec[1]  = mis_q ? STAT_FAIL_C : STAT_PASS_C;
      rec[2]  = idx_q;
      rec[3]  = expected_q[31:24];
      rec[4]  = expected_q[23:16];
      rec[5]  = expected_q[15:8];
      rec[6]  = expected_q[7:0];
      rec[7]  = measured_q[31:24];
      rec[8]  = measured_q[23:16];
      rec[9]  = measured_q[15:8];
      rec[10] = measured_q[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    test_count_d = test_count_q;
    fail_count_d = fail_count_q;
    passed_d     = passed_q;
    failed_d     = failed_q;
    done_pend_d  = done_pend_q;
    mis_d        = mis_q;
    expected_d   = expected_q;
    measured_d   = measured_q;
    idx_d        = idx_q;
    ser_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          expected_d  = cmp_expected;
          measured_d  = cmp_measured;
          idx_d       = tc16[7:0];
          mis_d       = (cmp_expected != cmp_measured);
          done_pend_d = done_pend_q || done_req;
          if (test_count_q != '1) test_count_d = test_count_q + COUNT_W'(1);
          if (mis_d) begin
            failed_d = 1'b1;
            if (fail_count_q != '1) fail_count_d = fail_count_q + COUNT_W'(1);
          end
          ser_start = 1'b1;
          state_d   = ST_SEND_REC;
        end else if (done_req || done_pend_q) begin
          done_pend_d = 1'b0;
          state_d     = ST_SEND_SUM;
        end
      end
      ST_SEND_REC: begin
        if (done_req) done_pend_d = 1'b1;
        if (ser_last) state_d = ST_IDLE;
      end
      ST_SEND_SUM: begin
        if (!byte_valid) ser_start = 1'b1;
        if (ser_last) begin
          state_d = ST_FINISHED;
          if (result == STAT_PASS_C) passed_d = 1'b1;
          else                       failed_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (timeout) begin
      state_d   = ST_SEND_SUM;
      failed_d  = 1'b1;
      passed_d  = passed_q;
      ser_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      test_count_q <= '0;
      fail_count_q <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      done_pend_q  <= 1'b0;
      mis_q        <= 1'b0;
      expected_q   <= '0;
      measured_q   <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      test_count_q <= test_count_d;
      fail_count_q <= fail_count_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      done_pend_q  <= done_pend_d;
      mis_q        <= mis_d;
      expected_q   <= expected_d;
      measured_q   <= measured_d;
      idx_q        <= idx_d;
    end
  end

  compare_reporter_ser u_ser (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (ser_start),
    .abort_i         (timeout),
    .len_i           (rec_len),
    .rec_i           (rec),
    .byte_ready_i    (byte_ready),
    .byte_valid_o    (byte_valid),
    .byte_data_o     (byte_data),
    .last_accepted_o (ser_last)
  );

  assign test_count  = test_count_q;
  assign fail_count  = fail_count_q;
  assign test_passed = passed_q;
  assign test_failed = failed_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_compare_reporter.sv
// Self-checking bench for compare_reporter: record-level model, per-cycle
// compare process and directed vectors with literal expectations.
module tb_compare_reporter;
  import compare_reporter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmp_valid = 1'b0;
  logic        cmp_ready;
  logic [31:0] cmp_expected = '0;
  logic [31:0] cmp_measured = '0;
  logic        done_req = 1'b0;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_data;
  logic [15:0] test_count, fail_count;
  logic        test_passed, test_failed;
  state_e      dbg_state;

  compare_reporter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmp_valid    (cmp_valid),
    .cmp_ready    (cmp_ready),
    .cmp_expected (cmp_expected),
    .cmp_measured (cmp_measured),
    .done_req     (done_req),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .test_count   (test_count),
    .fail_count   (fail_count),
    .test_passed  (test_passed),
    .test_failed  (test_failed),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          vectors = 0;
  int          errors  = 0;
  logic [7:0]  exp_q[$];
  int          kind_q[$];     // 0 plain byte, 1 last summary byte 'P', 2 last summary byte 'F'
  logic [7:0]  cap_q[$];
  logic [15:0] m_tests = '0, m_fails = '0;
  logic        m_passed = 1'b0, m_failed = 1'b0, m_finished = 1'b0;
  bit          bp_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_b(input logic [7:0] b, input int k);
    exp_q.push_back(b);
    kind_q.push_back(k);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    kind_q.delete();
    cap_q.delete();
    m_tests = '0; m_fails = '0;
    m_passed = 1'b0; m_failed = 1'b0; m_finished = 1'b0;
  endfunction

  function automatic void model_cmp(input logic [31:0] e, input logic [31:0] m);
    push_b(8'hA5, 0);
    push_b((e == m) ? 8'h50 : 8'h46, 0);
    push_b(m_tests[7:0], 0);
    for (int i = 3; i >= 0; i--) push_b(e[i*8 +: 8], 0);
    for (int i = 3; i >= 0; i--) push_b(m[i*8 +: 8], 0);
    if (m_tests != 16'hFFFF) m_tests++;
    if (e != m) begin
      if (m_fails != 16'hFFFF) m_fails++;
      m_failed = 1'b1;
    end
  endfunction

  function automatic void model_done();
    logic [7:0] res;
    if (m_finished) return;
    m_finished = 1'b1;
    res = (m_fails == 0 && m_tests == 16'd16) ? 8'h50 : 8'h46;
    push_b(8'h5A, 0);
    push_b(res, 0);
    push_b(m_tests[15:8], 0);
    push_b(m_tests[7:0], 0);
    push_b(8'h00, 0);
    push_b(8'h10, (res == 8'h50) ? 1 : 2);
  endfunction

  // Compare process: every negedge checks stream bytes, holding and flags.
  initial begin : compare_proc
    int         pend;
    logic       pv, pr;
    logic [7:0] pd, b;
    pend = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        pv   = 1'b0;
      end else begin
        if (pend == 1) m_passed = 1'b1;
        else if (pend == 2) m_failed = 1'b1;
        pend = 0;
        if (pv && !pr) begin
          chk("hold_valid", byte_valid, 1);
          chk("hold_data", byte_data, pd);
        end
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL extra_byte: got %h, expected no byte (t=%0t)", byte_data, $time);
          end else begin
            b    = exp_q.pop_front();
            pend = kind_q.pop_front();
            chk("stream_byte", byte_data, b);
            cap_q.push_back(byte_data);
          end
        end
        pv = byte_valid; pr = byte_ready; pd = byte_data;
      end
      chk("test_count", test_count, m_tests);
      chk("fail_count", fail_count, m_fails);
      chk("test_passed", test_passed, m_passed);
      chk("test_failed", test_failed, m_failed);
      chk("flags_exclusive", test_passed && test_failed, 0);
    end
  end

  // byte_ready driver: constant 1, or pseudo-random stalls in backpressure mode.
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      byte_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmp(input logic [31:0] e, input logic [31:0] m);
    int n;
    n = 0;
    cmp_valid = 1'b1; cmp_expected = e; cmp_measured = m;
    @(negedge clk);
    while (!cmp_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmp_ready) begin
      chk("cmp_ready_wait", cmp_ready, 1);
      cmp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmp_valid = 1'b0;
    model_cmp(e, m);
  endtask

  task automatic send_done();
    done_req = 1'b1;
    @(posedge clk);
    #1;
    done_req = 1'b0;
    model_done();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_q.size() == 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_cmp_ready", cmp_ready, 1);
    chk("rst_test_count", test_count, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_flags", {test_passed, test_failed}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tail(input string name, input logic [7:0] lit[6]);
    int base;
    base = cap_q.size() - 6;
    chk({name, "_len"}, (base >= 0), 1);
    if (base >= 0)
      for (int k = 0; k < 6; k++) chk(name, cap_q[base + k], lit[k]);
  endtask

  // ---------------- directed vectors ----------------
  logic [7:0] lit_rec1[11] = '{8'hA5, 8'h50, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] lit_pass[6]  = '{8'h5A, 8'h50, 8'h00, 8'h10, 8'h00, 8'h10};
  logic [7:0] lit_cnt[6]   = '{8'h5A, 8'h46, 8'h00, 8'h0F, 8'h00, 8'h10};
  logic [7:0] lit_one[6]   = '{8'h5A, 8'h46, 8'h00, 8'h01, 8'h00, 8'h10};

  initial begin : main
    int n;
    logic [31:0] r;
    #1;
    do_reset();

    // Single match: latency and literal record.
    send_cmp(32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    chk("ready_low_after_accept", cmp_ready, 0);
    n = 1;
    while (!cmp_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_latency", n, 12);
    @(posedge clk);
    #1;
    chk("rec1_len", cap_q.size(), 11);
    for (int k = 0; k < 11; k++) chk("rec1_byte", cap_q[k], lit_rec1[k]);
    chk("rec1_test_count", test_count, 1);
    chk("rec1_fail_count", fail_count, 0);

    // Mismatch.
    send_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEE);
    @(negedge clk);
    chk("fail_next_cycle", test_failed, 1);
    chk("fail_count_one", fail_count, 1);
    drain();
    chk("mis_status", cap_q[cap_q.size() - 10], 8'h46);
    chk("mis_index", cap_q[cap_q.size() - 9], 8'h01);

    // Backpressure with random data, every other pair mismatching.
    bp_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      send_cmp(r, (i % 2 == 0) ? r : r ^ 32'($urandom_range(1, 255)));
    end
    drain();
    bp_mode = 1'b0;
    chk("bp_test_count", test_count, 8);

    // Full pass, then FINISHED ignores further requests.
    do_reset();
    for (int i = 0; i < 16; i++) send_cmp(32'h0101_0101 * i, 32'h0101_0101 * i);
    send_done();
    drain();
    chk_tail("sum_pass", lit_pass);
    chk("pass_flag", test_passed, 1);
    chk("pass_no_fail", test_failed, 0);
    chk("finished_ready", cmp_ready, 0);
    cmp_valid = 1'b1;
    send_done();
    repeat (3) @(posedge clk);
    #1;
    cmp_valid = 1'b0;
    drain();
    chk("finished_count", test_count, 16);

    // Count error: 15 compares.
    do_reset();
    for (int i = 0; i < 15; i++) send_cmp(32'hC0DE_0000 + i, 32'hC0DE_0000 + i);
    send_done();
    drain();
    chk_tail("sum_count_err", lit_cnt);
    chk("cnt_err_failed", test_failed, 1);
    chk("cnt_err_not_passed", test_passed, 0);

    // done_req arriving while a record is still streaming.
    do_reset();
    send_cmp(32'hAAAA_5555, 32'hAAAA_5555);
    repeat (3) @(posedge clk);
    #1;
    send_done();
    drain();
    chk("pend_total_len", cap_q.size(), 17);
    chk_tail("sum_pending", lit_one);

    // Reset in the middle of a record, on byte 5.
    do_reset();
    send_cmp(32'h1122_3344, 32'h1122_3344);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_valid", byte_valid, 1);
    chk("mid_byte5", byte_data, 8'h22);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", byte_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/compare_reporter.md
Name: compare_reporter

Overview:
Synthesizable producer side of the pass/fail check flow. It accepts expected/measured word pairs from on-chip self-check logic, compares them, keeps pass/fail counts, and serializes one fixed-format result record per comparison onto a byte stream. The bench-side checker or a UART transmitter consumes that stream. On a done request it emits a summary record and asserts a sticky pass or fail flag.

Parameters:
NUMBER_OF_TESTS, 16, expected number of comparisons before done
COUNT_W, 16, width of test and fail counters
SYNC_BYTE, 8'hA5, first byte of every per-test record
SUM_BYTE, 8'h5A, first byte of the summary record

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmp_valid  in  1  comparison request valid
cmp_ready  out  1  block can accept a comparison
cmp_expected  in  32  expected value
cmp_measured  in  32  measured value
done_req  in  1  single-cycle pulse: all tests issued
byte_valid  out  1  byte_data valid
byte_ready  in  1  downstream accepts byte
byte_data  out  8  serialized record byte
test_count  out  COUNT_W  comparisons accepted
fail_count  out  COUNT_W  mismatches seen
test_passed  out  1  sticky, summary said pass
test_failed  out  1  sticky, any mismatch, count error or timeout

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n). Every flop is on posedge clk or negedge rst_n.
- Reset values: cmp_ready=1, byte_valid=0, byte_data=0, counts=0, test_passed=0, test_failed=0. The FSM resets to IDLE.
- States: IDLE, SEND_REC, SEND_SUM, FINISHED.
- IDLE:
  - A cmp_valid&&cmp_ready transfer latches expected and measured.
  - It computes mismatch = (expected != measured) and increments test_count. On mismatch it also increments fail_count and sets test_failed.
  - It moves to SEND_REC with cmp_ready=0.
- Per-test record, 11 bytes:
  - SYNC_BYTE
  - status: 8'h50 'P' or 8'h46 'F'
  - test index (pre-increment count, low 8 bits)
  - expected, MSB first (4 bytes)
  - measured, MSB first (4 bytes)
- Stream handshake:
  - byte_valid holds and byte_data stays stable until byte_ready.
  - The byte index advances only on valid&&ready.
  - The first byte appears the cycle after the accept.
  - After the last byte is accepted, the FSM returns to IDLE and cmp_ready=1 the next cycle.
  - Minimum throughput is 12 cycles per comparison.
- done_req:
  - Sampled only in IDLE. If it arrives during SEND_REC, it is registered pending and serviced on return to IDLE.
  - If done_req and cmp_valid are both present in the same IDLE cycle, the comparison is served first.
  - Service moves to SEND_SUM.
- Summary record, 6 bytes: SUM_BYTE, result byte, test_count[15:8], test_count[7:0], NUMBER_OF_TESTS[15:8], NUMBER_OF_TESTS[7:0].
  - result = 'P' iff fail_count==0 and test_count==NUMBER_OF_TESTS, else 'F'.
  - On the last summary byte accept: 'P' sets test_passed; 'F' sets test_failed. The FSM enters FINISHED.
- FINISHED: cmp_ready=0; further done_req and cmp_valid are ignored. Only reset exits.
- Counter wrap: counters saturate at all-ones and do not wrap. A saturated test_count forces 'F'.
- test_passed and test_failed are never both 1.
- Reset mid-record: the stream is abandoned immediately (byte_valid=0). There is no partial-record completion.

Optional Feature:
COMPARE_REPORTER_TIMEOUT_EN.
- With the macro: add parameter TIMEOUT_CYCLES (default 1_000_000) and a watchdog counter.
  - The counter clears on any cmp or byte transfer and counts otherwise in IDLE/SEND_REC/SEND_SUM.
  - On reaching TIMEOUT_CYCLES it sets test_failed and drops any in-flight record (byte_valid=0 next cycle).
  - It then emits the summary with result byte 8'h54 'T' and enters FINISHED.
- Without the macro: no watchdog logic and no 'T' status. The block can wait forever.

Decomposition:
- Shared package holds:
  - state enum
  - record byte constants (SYNC, SUM, 'P', 'F', 'T')
  - record lengths (11, 6)
  - COUNT_W default
- One natural sub-module: compare_reporter_ser. It is a byte-index mux plus valid/ready holding register, shared by both record types. It is given a record length and returns last_accepted.

Test Plan:
- Single match: exp=32'h1234_5678, meas=32'h1234_5678, byte_ready=1 -> stream A5 50 00 12 34 56 78 12 34 56 78; test_count=1, fail_count=0; cmp_ready high again 12 cycles after accept.
- Mismatch: exp=32'hDEAD_BEEF, meas=32'hDEAD_BEEE -> status 46; fail_count=1; test_failed=1 the cycle after accept.
- Backpressure: byte_ready toggles 1-0-0-1 pseudo-randomly -> byte_data is stable while valid&&!ready; no bytes lost or duplicated.
- Full pass: 16 matching compares, then done_req -> summary 5A 50 00 10 00 10; test_passed=1, test_failed=0.
- Count error: 15 compares then done_req -> summary 5A 46 00 0F 00 10; test_failed=1.
- done_req during a record plus reset mid-record: done is serviced after the record; rst_n low on byte 5 -> byte_valid=0 and counts=0 immediately.
